// File: rtl/da_shift_accumulator.sv
// Bit-plane shift-accumulator for the DA FIR datapath: resolves each redundant
// sum/carry plane, weights it by 2^k, and emits one signed sample per B planes.
module da_shift_accumulator #(
    parameter int IN_W  = 16,
    parameter int B     = 16,
    parameter int OUT_W = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic [IN_W-1:0]  in_sum,
    input  logic [IN_W-1:0]  in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             frame_err
);
    localparam int KW = (B > 1) ? $clog2(B) : 1;
    localparam int PW = IN_W + 2;
    localparam logic [KW-1:0] K_LAST = KW'(B - 1);

    logic [KW-1:0]    k_reg;
    logic [OUT_W-1:0] acc_reg;
    logic             out_valid_reg;
    logic [OUT_W-1:0] out_data_reg;
    logic             frame_err_reg;

    logic [PW-1:0]    p;
    logic [OUT_W-1:0] p_ext;
    logic [OUT_W-1:0] p_shift;
    logic [OUT_W-1:0] acc_base;
    logic [OUT_W-1:0] acc_next;
    logic [KW-1:0]    k_eff;
    logic             accept;
    logic             last_plane;
    logic             restart;
    logic             missing_first;
    logic             load_result;

    // sum + 2*carry at IN_W+2 bits cannot overflow
    assign p = {{2{in_sum[IN_W-1]}}, in_sum} + {in_carry[IN_W-1], in_carry, 1'b0};
    assign p_ext = {{(OUT_W - PW){p[PW-1]}}, p};

    // A plane flagged in_first always restarts the sample at plane 0
    assign k_eff    = in_first ? '0 : k_reg;
    assign p_shift  = p_ext << k_eff;
    assign acc_base = (k_eff == '0) ? '0 : acc_reg;
    assign last_plane = (k_eff == K_LAST);
    assign acc_next = last_plane ? (acc_base - p_shift) : (acc_base + p_shift);

    // Only the plane that would overwrite a stalled result is held off
    assign in_ready = !((k_reg == K_LAST) && out_valid_reg && !out_ready);
    assign accept   = in_valid && in_ready;

    assign restart       = in_first && (k_reg != '0);
    assign missing_first = !in_first && (k_reg == '0);
    assign load_result   = accept && last_plane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg         <= '0;
            acc_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= accept && (restart || missing_first);
            if (accept) begin
                if (last_plane) begin
                    k_reg   <= '0;
                    acc_reg <= '0;
                end else begin
                    k_reg   <= k_eff + KW'(1);
                    acc_reg <= acc_next;
                end
            end
            if (load_result) begin
                out_data_reg  <= acc_next;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_da_shift_accumulator.sv
// Randomized self-checking bench for da_shift_accumulator (B=4, IN_W=8, OUT_W=14)
// against a plane-list reference model.
module tb_da_shift_accumulator;
    localparam int IN_W  = 8;
    localparam int B     = 4;
    localparam int OUT_W = 14;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_first;
    logic [IN_W-1:0]  in_sum;
    logic [IN_W-1:0]  in_carry;
    logic             out_ready;
    logic             in_ready;
    logic             out_valid;
    logic             frame_err;
    logic [OUT_W-1:0] out_data;

    int total = 0;
    int bad   = 0;

    // Reference model: planes of the sample in progress, completed results in order
    longint           planes[$];
    logic [OUT_W-1:0] exp_q[$];

    logic             obs_rdy, obs_ov, obs_fe;
    logic [OUT_W-1:0] obs_data;
    logic             exp_rdy, exp_ov, exp_fe;
    logic [OUT_W-1:0] exp_data;

    da_shift_accumulator #(.IN_W(IN_W), .B(B), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] model_result();
        longint r;
        r = 0;
        for (int i = 0; i < B; i++) begin
            if (i == B - 1) r = r - planes[i] * (longint'(1) << i);
            else            r = r + planes[i] * (longint'(1) << i);
        end
        return r[OUT_W-1:0];
    endfunction

    // One clock cycle: drive at negedge, observe, update the model, observe frame_err after posedge
    task automatic step(input logic v, input logic [IN_W-1:0] s, input logic [IN_W-1:0] c,
                        input logic f, input logic ordy);
        longint pv;
        @(negedge clk);
        in_valid = v; in_sum = s; in_carry = c; in_first = f; out_ready = ordy;
        #1;
        obs_rdy  = in_ready;
        obs_ov   = out_valid;
        obs_data = out_data;
        exp_ov   = (exp_q.size() != 0);
        exp_rdy  = !((planes.size() == B - 1) && exp_ov && !ordy);
        exp_data = exp_ov ? exp_q[0] : '0;
        if (exp_ov && ordy) void'(exp_q.pop_front());
        exp_fe = 1'b0;
        if (v && exp_rdy) begin
            pv = longint'($signed(s)) + 2 * longint'($signed(c));
            exp_fe = f ? (planes.size() != 0) : (planes.size() == 0);
            if (f) planes.delete();
            planes.push_back(pv);
            if (planes.size() == B) begin
                exp_q.push_back(model_result());
                planes.delete();
            end
        end
        @(posedge clk);
        #1;
        obs_fe = frame_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; in_first = 0; in_sum = '0; in_carry = '0; out_ready = 1;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || frame_err !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state got ov=%b data=%h fe=%b rdy=%b want ov=0 data=0000 fe=0 rdy=1",
                     out_valid, out_data, frame_err, in_ready);
        end
        rst_n = 1'b1;
        planes.delete(); exp_q.delete();
    endtask

    task automatic test_basic();
        logic [IN_W-1:0]  s_tab[3];
        logic [IN_W-1:0]  c_tab[3];
        logic [OUT_W-1:0] want[3];
        s_tab = '{8'h01, 8'h03, 8'hFF};
        c_tab = '{8'h00, 8'h01, 8'h00};
        want  = '{14'h3FFF, 14'h3FFB, 14'h0001};
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < B; k++) begin
                step(1'b1, s_tab[t], c_tab[t], k == 0, 1'b1);
                total++;
                if (obs_fe !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_frame_err t=%0d k=%0d got=%b want=0", t, k, obs_fe);
                end
            end
            step(1'b0, '0, '0, 1'b0, 1'b1);
            total++;
            if (obs_ov !== 1'b1 || obs_data !== want[t]) begin
                bad++;
                $display("FAIL basic_result t=%0d got ov=%b data=%h want ov=1 data=%h",
                         t, obs_ov, obs_data, want[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nv;
        nv = 0;
        for (int i = 0; i < 5 * B + 1; i++) begin
            if (i < 5 * B) step(1'b1, IN_W'($urandom), IN_W'($urandom), (i % B) == 0, 1'b1);
            else           step(1'b0, '0, '0, 1'b0, 1'b1);
            if (obs_ov) nv++;
            total++;
            if (obs_rdy !== 1'b1 || obs_ov !== exp_ov || (exp_ov && obs_data !== exp_data)) begin
                bad++;
                $display("FAIL b2b i=%0d got rdy=%b ov=%b data=%h want rdy=1 ov=%b data=%h",
                         i, obs_rdy, obs_ov, obs_data, exp_ov, exp_data);
            end
        end
        total++;
        if (nv != 5) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=5", nv);
        end
    endtask

    task automatic test_backpressure();
        logic [OUT_W-1:0] held;
        logic [IN_W-1:0]  s3, c3;
        for (int k = 0; k < B; k++) step(1'b1, IN_W'($urandom), IN_W'($urandom), k == 0, 1'b1);
        held = exp_q[0];
        for (int k = 0; k < B - 1; k++) begin
            step(1'b1, IN_W'($urandom), IN_W'($urandom), k == 0, 1'b0);
            total++;
            if (obs_rdy !== 1'b1 || obs_ov !== 1'b1 || obs_data !== held) begin
                bad++;
                $display("FAIL stall_accept k=%0d got rdy=%b ov=%b data=%h want rdy=1 ov=1 data=%h",
                         k, obs_rdy, obs_ov, obs_data, held);
            end
        end
        s3 = IN_W'($urandom); c3 = IN_W'($urandom);
        repeat (2) begin
            step(1'b1, s3, c3, 1'b0, 1'b0);
            total++;
            if (obs_rdy !== 1'b0 || obs_ov !== 1'b1 || obs_data !== held) begin
                bad++;
                $display("FAIL stall_block got rdy=%b ov=%b data=%h want rdy=0 ov=1 data=%h",
                         obs_rdy, obs_ov, obs_data, held);
            end
        end
        step(1'b1, s3, c3, 1'b0, 1'b1);
        total++;
        if (obs_rdy !== 1'b1 || obs_ov !== 1'b1 || obs_data !== held) begin
            bad++;
            $display("FAIL stall_release got rdy=%b ov=%b data=%h want rdy=1 ov=1 data=%h",
                     obs_rdy, obs_ov, obs_data, held);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1);
        total++;
        if (obs_ov !== 1'b1 || obs_data !== exp_data) begin
            bad++;
            $display("FAIL stall_second got ov=%b data=%h want ov=1 data=%h", obs_ov, obs_data, exp_data);
        end
    endtask

    task automatic test_frame_err();
        step(1'b1, IN_W'($urandom), IN_W'($urandom), 1'b1, 1'b1);
        step(1'b1, IN_W'($urandom), IN_W'($urandom), 1'b0, 1'b1);
        step(1'b1, IN_W'($urandom), IN_W'($urandom), 1'b1, 1'b1);
        total++;
        if (obs_fe !== 1'b1) begin
            bad++;
            $display("FAIL restart_pulse got=%b want=1", obs_fe);
        end
        for (int k = 1; k < B; k++) begin
            step(1'b1, IN_W'($urandom), IN_W'($urandom), 1'b0, 1'b1);
            total++;
            if (obs_fe !== 1'b0) begin
                bad++;
                $display("FAIL restart_quiet k=%0d got=%b want=0", k, obs_fe);
            end
        end
        step(1'b0, '0, '0, 1'b0, 1'b1);
        total++;
        if (obs_ov !== 1'b1 || obs_data !== exp_data) begin
            bad++;
            $display("FAIL restart_result got ov=%b data=%h want ov=1 data=%h", obs_ov, obs_data, exp_data);
        end
        step(1'b1, IN_W'($urandom), IN_W'($urandom), 1'b0, 1'b1);
        total++;
        if (obs_fe !== 1'b1) begin
            bad++;
            $display("FAIL missing_first_pulse got=%b want=1", obs_fe);
        end
        for (int k = 1; k < B; k++) step(1'b1, IN_W'($urandom), IN_W'($urandom), 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        total++;
        if (obs_ov !== 1'b1 || obs_data !== exp_data) begin
            bad++;
            $display("FAIL missing_first_result got ov=%b data=%h want ov=1 data=%h",
                     obs_ov, obs_data, exp_data);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < B; k++) step(1'b1, IN_W'($urandom), IN_W'($urandom), k == 0, 1'b1);
        step(1'b1, IN_W'($urandom), IN_W'($urandom), 1'b1, 1'b0);
        step(1'b1, IN_W'($urandom), IN_W'($urandom), 1'b0, 1'b0);
        total++;
        if (obs_ov !== 1'b1) begin
            bad++;
            $display("FAIL areset_setup got ov=%b want=1", obs_ov);
        end
        @(negedge clk);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL areset_clear got ov=%b data=%h rdy=%b fe=%b want ov=0 data=0000 rdy=1 fe=0",
                     out_valid, out_data, in_ready, frame_err);
        end
        planes.delete(); exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < B; k++) step(1'b1, IN_W'($urandom), IN_W'($urandom), k == 0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        total++;
        if (obs_ov !== 1'b1 || obs_data !== exp_data) begin
            bad++;
            $display("FAIL areset_fresh got ov=%b data=%h want ov=1 data=%h", obs_ov, obs_data, exp_data);
        end
    endtask

    task automatic test_random();
        logic v, f, ordy;
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            f    = (planes.size() == 0);
            if ($urandom_range(0, 19) == 0) f = !f;
            step(v, IN_W'($urandom), IN_W'($urandom), f, ordy);
            total++;
            if (obs_rdy !== exp_rdy || obs_ov !== exp_ov || obs_fe !== exp_fe ||
                (exp_ov && obs_data !== exp_data)) begin
                bad++;
                $display("FAIL random i=%0d got rdy=%b ov=%b fe=%b data=%h want rdy=%b ov=%b fe=%b data=%h",
                         i, obs_rdy, obs_ov, obs_fe, obs_data, exp_rdy, exp_ov, exp_fe, exp_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_frame_err();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
